// File: rtl/alu_serial_sequencer.sv
// ---------------------------------------------------------------------------
// alu_serial_sequencer
//
// Purpose:
//   Wraps an external 1-bit combinational ALU. A WIDTH-bit operand pair and a
//   2-bit opcode are accepted through a valid/ready handshake. The operands
//   are fed to the ALU one bit per clock, LSB first. Each returned ALU bit is
//   shifted into a result register. The assembled WIDTH-bit result is then
//   offered downstream through a second valid/ready handshake.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands/opcode presented
//   in_ready   out  1      high only while idle
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_op      in   2      ALU opcode
//   alu_a      out  1      current A bit to the ALU (0 outside SHIFT)
//   alu_b      out  1      current B bit to the ALU (0 outside SHIFT)
//   alu_op     out  2      opcode to the ALU, held for the whole operation
//   alu_out    in   1      ALU result bit for the current alu_a/alu_b/alu_op
//   res_valid  out  1      result available
//   res_ready  in   1      consumer accepts the result
//   res_data   out  WIDTH  assembled result, bit i = ALU result of bit i
//   res_zero   out  1      only with ALU_ZERO_FLAG_EN: res_data==0 while valid
//
// Configuration:
//   ALU_ZERO_FLAG_EN  when defined, adds the registered res_zero output.
// ---------------------------------------------------------------------------
module alu_serial_sequencer #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             alu_a,
  output logic             alu_b,
  output logic [1:0]       alu_op,
  input  logic             alu_out,
  output logic             res_valid,
  input  logic             res_ready,
`ifdef ALU_ZERO_FLAG_EN
  output logic             res_zero,
`endif
  output logic [WIDTH-1:0] res_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sh_a_q, sh_a_d;
  logic [WIDTH-1:0]   sh_b_q, sh_b_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   res_q, res_d;

  // Next-state logic. In SHIFT the operand registers move right so bit 0
  // always holds the bit currently presented to the ALU. The returned bit
  // enters the result register at the MSB. After WIDTH shifts the first bit
  // has arrived at position 0. Unused state encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    op_d    = op_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_a_d  = in_a;
          sh_b_d  = in_b;
          op_d    = in_op;
          cnt_d   = '0;
          res_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d  = {alu_out, res_q[WIDTH-1:1]};
        sh_a_d = {1'b0, sh_a_q[WIDTH-1:1]};
        sh_b_d = {1'b0, sh_b_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

`ifdef ALU_ZERO_FLAG_EN
  logic res_zero_q, res_zero_d;

  // The zero flag is registered together with the result. It is therefore
  // only high in the cycles where DONE presents an all-zero result.
  always_comb begin
    res_zero_d = (state_d == DONE) && (res_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_zero_q <= 1'b0;
    end else begin
      res_zero_q <= res_zero_d;
    end
  end

  assign res_zero = res_zero_q;
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  // Outputs are decoded from registered state only. No handshake input or
  // alu_out can reach an output combinationally.
  assign in_ready  = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign alu_a     = (state_q == SHIFT) ? sh_a_q[0] : 1'b0;
  assign alu_b     = (state_q == SHIFT) ? sh_b_q[0] : 1'b0;
  assign alu_op    = op_q;
  assign res_data  = res_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_serial_sequencer
//
// Directed testbench for alu_serial_sequencer with WIDTH=8. A small
// behavioural ALU closes the loop: op 0=AND, 1=OR, 2=XOR, 3=~a. Issued
// operations push their hand-computed result into a queue. A monitor pops
// the queue and compares on each result handshake. Protocol details are
// checked inline: latency, hold, ignored input and abort.
// ---------------------------------------------------------------------------
module tb_alu_serial_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [1:0] in_op;
  logic       alu_a;
  logic       alu_b;
  logic [1:0] alu_op;
  logic       alu_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
`ifdef ALU_ZERO_FLAG_EN
  logic       res_zero;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  alu_serial_sequencer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
`ifdef ALU_ZERO_FLAG_EN
    .res_zero  (res_zero),
`endif
    .res_data  (res_data)
  );

  // Clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 1-bit ALU that closes the loop around the sequencer.
  always_comb begin
    case (alu_op)
      2'd0:    alu_out = alu_a & alu_b;
      2'd1:    alu_out = alu_a | alu_b;
      2'd2:    alu_out = alu_a ^ alu_b;
      default: alu_out = ~alu_a;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Waits for in_ready, presents one operation for a single accepting edge,
  // and queues the expected result unless the operation will be aborted.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [1:0] op, input logic [7:0] exp_res,
                               input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    if (push) exp_q.push_back(exp_res);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits for res_valid within a bound and returns the number of edges.
  task automatic waitValid(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!res_valid) checkOutput("valid_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard monitor. It compares on every result handshake, sampled on
  // the falling edge.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_result", 32'(res_data), 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        checkOutput("res_data", 32'(res_data), 32'(e));
`ifdef ALU_ZERO_FLAG_EN
        checkOutput("res_zero", 32'(res_zero), 32'(e == 8'h00));
`endif
      end
    end
  end

  initial begin
    int cyc;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    res_ready = 1'b1;

    // Reset held for two clocks.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_data", 32'(res_data), 32'h00);
    checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
    checkOutput("rst_alu_a", 32'(alu_a), 32'd0);
`ifdef ALU_ZERO_FLAG_EN
    checkOutput("rst_res_zero", 32'(res_zero), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // AND: latency of 8 edges and a one-cycle valid pulse.
    applyStimulus(8'hF0, 8'h3C, 2'd0, 8'h30, 1'b1);
    checkOutput("shift_alu_op", 32'(alu_op), 32'd0);
    waitValid(cyc);
    checkOutput("latency", 32'(cyc), 32'd8);
    @(posedge clk); #1;
    checkOutput("pulse_one_cycle", 32'(res_valid), 32'd0);
    checkOutput("back_in_idle", 32'(in_ready), 32'd1);

    // XOR with consumer stall: the result is held for 5 clocks.
    res_ready = 1'b0;
    applyStimulus(8'hA5, 8'h0F, 2'd2, 8'hAA, 1'b1);
    waitValid(cyc);
    checkOutput("done_alu_a", 32'(alu_a), 32'd0);
    checkOutput("done_alu_op", 32'(alu_op), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("stall_valid", 32'(res_valid), 32'd1);
      checkOutput("stall_data", 32'(res_data), 32'hAA);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_after_ready", 32'(in_ready), 32'd1);
    checkOutput("data_kept", 32'(res_data), 32'hAA);

    // in_valid held during SHIFT with different operands must be ignored.
    applyStimulus(8'h3C, 8'hC3, 2'd1, 8'hFF, 1'b1);
    in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; in_op = 2'd0;
    cyc = 0;
    while (!res_valid && cyc < 40) begin
      checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("busy_latency", 32'(cyc), 32'd8);
    checkOutput("done_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Abort after 3 SHIFT clocks: no result, and reset values next clock.
    applyStimulus(8'h55, 8'hAA, 2'd1, 8'hFF, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checkOutput("abort_no_valid", 32'(res_valid), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_res_valid", 32'(res_valid), 32'd0);
    checkOutput("abort_res_data", 32'(res_data), 32'h00);
    checkOutput("abort_alu_op", 32'(alu_op), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("abort_still_idle", 32'(res_valid), 32'd0);

    // Zero and all-ones results, plus the invert opcode.
    applyStimulus(8'hF0, 8'h0F, 2'd0, 8'h00, 1'b1);
    applyStimulus(8'hF0, 8'h0F, 2'd1, 8'hFF, 1'b1);
    applyStimulus(8'h0F, 8'h99, 2'd3, 8'hF0, 1'b1);
    applyStimulus(8'h81, 8'h01, 2'd2, 8'h80, 1'b1);

    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
